// File: rtl/serial_full_adder_seq.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// Streams each sum bit on ser_out and presents the parallel result with a done pulse.
module serial_full_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ser_out,
    output logic             ser_valid
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    // Only WIDTH-1 bits are stored: the final sum bit joins them on the last edge.
    logic [WIDTH-2:0] acc_reg;
    logic [WIDTH-2:0] acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ser_out_reg;
    logic             ser_valid_reg;

    logic s_bit;
    logic carry_next;

    assign s_bit      = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
    assign carry_next = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg)
                      | (b_sh_reg[0] & carry_reg);

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_acc
            if (gi == WIDTH - 2) begin : g_top
                assign acc_next[gi] = s_bit;
            end else begin : g_mid
                assign acc_next[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            c_out_reg     <= 1'b0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= c_in;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh_reg      <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg      <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    carry_reg     <= carry_next;
                    acc_reg       <= acc_next;
                    ser_out_reg   <= s_bit;
                    ser_valid_reg <= 1'b1;
                    cnt_reg       <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_CNT) begin
                        sum_reg   <= {s_bit, acc_reg};
                        c_out_reg <= carry_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ser_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign ser_out   = ser_out_reg;
    assign ser_valid = ser_valid_reg;
endmodule

// File: tb/tb_serial_full_adder_seq.sv
// Bench for serial_full_adder_seq: WIDTH=8 and WIDTH=5 instances checked every cycle
// against a timeline model derived from accept time and a+b+c_in.
module tb_serial_full_adder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ser8, sv8;
    logic [7:0] sum8;

    logic       start5 = 1'b0, cin5 = 1'b0;
    logic [4:0] a5 = '0, b5 = '0;
    logic       busy5, done5, cout5, ser5, sv5;
    logic [4:0] sum5;

    serial_full_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8),
        .ser_out(ser8), .ser_valid(sv8)
    );

    serial_full_adder_seq #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .c_in(cin5),
        .busy(busy5), .done(done5), .sum(sum5), .c_out(cout5),
        .ser_out(ser5), .ser_valid(sv5)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an op accepted at edge t is busy for edges t..t+W, emits result
    // bit k-1 at edge t+k, and publishes the result from edge t+W on.
    int  wd[2] = '{8, 5};
    bit  m_active[2];
    int  m_tacc[2];
    int  m_r[2];
    int  m_sum[2];
    int  m_cout[2];
    int  m_ser[2];
    bit  m_idle_before[2];
    int  ecnt = 0;

    function automatic bit in_start(input int d);
        return (d == 0) ? start8 : start5;
    endfunction

    function automatic int in_sum_ab(input int d);
        return (d == 0) ? (int'(a8) + int'(b8) + int'(cin8)) : (int'(a5) + int'(b5) + int'(cin5));
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    m_active[d] = 1'b0;
                    m_sum[d]    = 0;
                    m_cout[d]   = 0;
                    m_ser[d]    = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++)
                    m_idle_before[d] = !(m_active[d] && (ecnt - m_tacc[d]) <= wd[d]);
                ecnt++;
                for (int d = 0; d < 2; d++) begin
                    if (m_active[d] && (ecnt - m_tacc[d]) > wd[d]) begin
                        m_sum[d]    = m_r[d] & ((1 << wd[d]) - 1);
                        m_cout[d]   = (m_r[d] >> wd[d]) & 1;
                        m_ser[d]    = (m_r[d] >> (wd[d] - 1)) & 1;
                        m_active[d] = 1'b0;
                    end
                    if (m_idle_before[d] && in_start(d)) begin
                        m_active[d] = 1'b1;
                        m_tacc[d]   = ecnt;
                        m_r[d]      = in_sum_ab(d);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int k, w, e_sum, e_cout, e_ser;
                bit act, e_busy, e_done, e_valid;
                w       = wd[d];
                k       = ecnt - m_tacc[d];
                act     = m_active[d];
                e_busy  = act && k <= w;
                e_done  = act && k == w;
                e_valid = act && k >= 1 && k <= w;
                e_ser   = e_valid ? ((m_r[d] >> (k - 1)) & 1) : m_ser[d];
                e_sum   = (act && k >= w) ? (m_r[d] & ((1 << w) - 1)) : m_sum[d];
                e_cout  = (act && k >= w) ? ((m_r[d] >> w) & 1) : m_cout[d];
                check($sformatf("d%0d_busy", d), (d == 0) ? int'(busy8) : int'(busy5), int'(e_busy));
                check($sformatf("d%0d_done", d), (d == 0) ? int'(done8) : int'(done5), int'(e_done));
                check($sformatf("d%0d_ser_valid", d), (d == 0) ? int'(sv8) : int'(sv5), int'(e_valid));
                check($sformatf("d%0d_ser_out", d), (d == 0) ? int'(ser8) : int'(ser5), e_ser);
                check($sformatf("d%0d_sum", d), (d == 0) ? int'(sum8) : int'(sum5), e_sum);
                check($sformatf("d%0d_c_out", d), (d == 0) ? int'(cout8) : int'(cout5), e_cout);
            end
        end
    end

    task automatic drive(input int d, input bit s, input int av, input int bv, input bit cv);
        if (d == 0) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
        end else begin
            start5 = s; a5 = av[4:0]; b5 = bv[4:0]; cin5 = cv;
        end
    endtask

    task automatic set_start(input int d, input bit s);
        if (d == 0) start8 = s;
        else        start5 = s;
    endtask

    function automatic bit done_of(input int d);
        return (d == 0) ? done8 : done5;
    endfunction

    // Waits at negedges until done is seen; returns with the negedge inside DONE.
    task automatic wait_done(input int d, input string name, input bit scramble);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done_of(d)) got = 1'b1;
            else begin
                @(negedge clk);
                if (scramble) drive(d, 1'b1, int'($urandom), int'($urandom), 1'($urandom));
            end
        end
        if (!got) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic run_op(input int d, input int av, input int bv, input bit cv,
                          input bit hold, input int gap);
        int mask, r, s, c;
        mask = (1 << wd[d]) - 1;
        av &= mask;
        bv &= mask;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        drive(d, 1'b1, av, bv, cv);
        @(negedge clk);
        if (!hold) set_start(d, 1'b0);
        wait_done(d, "op", hold);
        set_start(d, 1'b0);
        r = av + bv + int'(cv);
        s = (d == 0) ? int'(sum8) : int'(sum5);
        c = (d == 0) ? int'(cout8) : int'(cout5);
        $display("op w=%0d a=%0h b=%0h cin=%0d -> sum=%0h c_out=%0d", wd[d], av, bv, cv, s, c);
        check("op_sum", s, r & mask);
        check("op_cout", c, (r >> wd[d]) & 1);
    endtask

    initial begin
        logic [7:0] ser_seq;
        bit done_seen;

        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_ser_valid", sv8, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        // 35 + 4A: bit-level timing
        @(negedge clk);
        drive(0, 1'b1, 'h35, 'h4A, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        check("t1_busy_e0", busy8, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ser_seq[k-1] = ser8;
            check($sformatf("t1_done_e%0d", k), done8, (k == 8) ? 1 : 0);
            check($sformatf("t1_busy_e%0d", k), busy8, 1);
        end
        check("t1_ser_seq", ser_seq, 'h7F);
        check("t1_sum", sum8, 'h7F);
        check("t1_cout", cout8, 0);
        $display("op w=8 a=35 b=4a cin=0 -> sum=%0h c_out=%0d", sum8, cout8);
        @(negedge clk);
        check("t1_busy_e9", busy8, 0);
        check("t1_done_e9", done8, 0);

        // Reset while idle clears outputs without a clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_idle_sum", sum8, 0);
        check("rst_idle_busy", busy8, 0);
        check("rst_idle_done", done8, 0);
        check("rst_idle_cout", cout8, 0);
        check("rst_idle_ser", ser8, 0);
        check("rst_idle_valid", sv8, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ops, second accepted at E10
        run_op(0, 'hFF, 'h01, 1'b0, 1'b0, 0);
        check("t2a_sum", sum8, 'h00);
        check("t2a_cout", cout8, 1);
        run_op(0, 'hFF, 'hFF, 1'b1, 1'b0, 0);
        check("t2b_sum", sum8, 'hFF);
        check("t2b_cout", cout8, 1);

        // Start during SHIFT is ignored
        @(negedge clk);
        drive(0, 1'b1, 'h10, 'h20, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 'hAA, 'h55, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, "t3", 1'b0);
        check("t3_sum", sum8, 'h30);
        check("t3_cout", cout8, 0);
        $display("op w=8 a=10 b=20 cin=0 -> sum=%0h c_out=%0d", sum8, cout8);
        @(negedge clk);
        check("t3_busy_after", busy8, 0);
        check("t3_done_after", done8, 0);
        drive(0, 1'b1, 'h01, 'h01, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_hold_sum", sum8, 'h30);
        wait_done(0, "t3b", 1'b0);
        check("t3b_sum", sum8, 'h02);
        $display("op w=8 a=1 b=1 cin=0 -> sum=%0h c_out=%0d", sum8, cout8);

        // Reset aborts an operation in progress
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 'h0F, 'h0F, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_busy_rst", busy8, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen = 1'b1;
        end
        check("t4_no_done", done_seen, 0);
        check("t4_sum", sum8, 0);
        check("t4_cout", cout8, 0);
        $display("op w=8 a=f b=f cin=0 aborted -> sum=%0h c_out=%0d", sum8, cout8);
        run_op(0, 'h80, 'h80, 1'b0, 1'b0, 0);
        check("t4b_sum", sum8, 'h00);
        check("t4b_cout", cout8, 1);

        // Random operations on both widths
        for (int i = 0; i < 200; i++)
            run_op(0, int'($urandom), int'($urandom), 1'($urandom),
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)));
        for (int i = 0; i < 200; i++)
            run_op(1, int'($urandom), int'($urandom), 1'($urandom),
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
